// File: rtl/dense_out.sv
// Final fully-connected layer: streams a feature vector and a weight matrix out of
// memory, accumulates one dot product per output, and writes scaled, saturated scores.
module dense_out #(
    parameter int SIZE_1           = 12,
    parameter int SIZE_address_pix = 13,
    parameter int SIZE_address_wei = 13,
    parameter int IN_NUM           = 16,
    parameter int OUT_NUM          = 11,
    parameter int SHIFT            = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        enable,
    output logic                        STOP,
    input  logic [SIZE_address_pix-1:0] memstartp,
    input  logic [SIZE_address_pix-1:0] memstartzap,
    input  logic [SIZE_1-1:0]           qp,
    output logic                        re,
    output logic [SIZE_address_pix-1:0] read_addressp,
    input  logic [SIZE_1-1:0]           qw,
    output logic                        re_wb,
    output logic [SIZE_address_wei-1:0] read_addressw,
    output logic                        we,
    output logic [SIZE_address_pix-1:0] write_addressp,
    output logic [SIZE_1-1:0]           dp
);
    localparam int IW = (IN_NUM > 1) ? $clog2(IN_NUM) : 1;
    localparam int OW = (OUT_NUM > 1) ? $clog2(OUT_NUM) : 1;
    localparam int PW = 2 * SIZE_1;
    localparam int AW = PW + $clog2(IN_NUM) + 1;

    localparam logic signed [AW-1:0] SAT_MAX = AW'((64'sd1 <<< (SIZE_1 - 1)) - 64'sd1);
    localparam logic signed [AW-1:0] SAT_MIN = ~SAT_MAX;
    localparam logic [IW-1:0]        I_LAST  = IW'(IN_NUM - 1);
    localparam logic [OW-1:0]        O_LAST  = OW'(OUT_NUM - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_DRAIN,
        S_WRITE,
        S_DONE
    } state_t;

    state_t                        state_q, state_d;
    logic [IW-1:0]                 i_q, i_d;
    logic [OW-1:0]                 o_q, o_d;
    logic signed [AW-1:0]          acc_q, acc_d;
    logic                          rd_q, rd_d;
    logic                          we_q, we_d;
    logic                          stop_q, stop_d;
    logic [SIZE_address_pix-1:0]   raddrp_q, raddrp_d;
    logic [SIZE_address_wei-1:0]   raddrw_q, raddrw_d;
    logic [SIZE_address_pix-1:0]   waddr_q, waddr_d;
    logic [SIZE_1-1:0]             dp_q, dp_d;

    logic signed [PW-1:0] qp_ext, qw_ext, prod;
    logic signed [AW-1:0] prod_ext, acc_sum;
    logic [IW-1:0]        i_nxt;

    // Operands are widened before the multiply so the full product is kept.
    assign qp_ext   = PW'($signed(qp));
    assign qw_ext   = PW'($signed(qw));
    assign prod     = qp_ext * qw_ext;
    assign prod_ext = AW'(prod);
    assign acc_sum  = acc_q + prod_ext;
    assign i_nxt    = i_q + IW'(1);

    function automatic logic [SIZE_1-1:0] saturate(input logic signed [AW-1:0] a);
        logic signed [AW-1:0] s;
        s = a >>> SHIFT;
        if (s > SAT_MAX) return SAT_MAX[SIZE_1-1:0];
        if (s < SAT_MIN) return SAT_MIN[SIZE_1-1:0];
        return s[SIZE_1-1:0];
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            i_q      <= '0;
            o_q      <= '0;
            acc_q    <= '0;
            rd_q     <= 1'b0;
            we_q     <= 1'b0;
            stop_q   <= 1'b0;
            raddrp_q <= '0;
            raddrw_q <= '0;
            waddr_q  <= '0;
            dp_q     <= '0;
        end else begin
            state_q  <= state_d;
            i_q      <= i_d;
            o_q      <= o_d;
            acc_q    <= acc_d;
            rd_q     <= rd_d;
            we_q     <= we_d;
            stop_q   <= stop_d;
            raddrp_q <= raddrp_d;
            raddrw_q <= raddrw_d;
            waddr_q  <= waddr_d;
            dp_q     <= dp_d;
        end
    end

    // Outputs are computed one state ahead so every port comes straight from a flop.
    always_comb begin
        state_d  = state_q;
        i_d      = i_q;
        o_d      = o_q;
        acc_d    = acc_q;
        rd_d     = 1'b0;
        we_d     = 1'b0;
        stop_d   = 1'b0;
        raddrp_d = raddrp_q;
        raddrw_d = raddrw_q;
        waddr_d  = waddr_q;
        dp_d     = dp_q;
        case (state_q)
            S_IDLE: begin
                if (enable) begin
                    state_d  = S_READ;
                    i_d      = '0;
                    o_d      = '0;
                    acc_d    = '0;
                    rd_d     = 1'b1;
                    raddrp_d = memstartp;
                    raddrw_d = '0;
                end
            end
            S_READ: begin
                if (!enable) begin
                    state_d = S_IDLE;
                    acc_d   = '0;
                end else begin
                    // Data arriving now belongs to the address issued last cycle.
                    if (i_q != '0) acc_d = acc_sum;
                    if (i_q == I_LAST) begin
                        state_d = S_DRAIN;
                    end else begin
                        i_d      = i_nxt;
                        rd_d     = 1'b1;
                        raddrp_d = memstartp + SIZE_address_pix'(i_nxt);
                        raddrw_d = raddrw_q + SIZE_address_wei'(1);
                    end
                end
            end
            S_DRAIN: begin
                if (!enable) begin
                    state_d = S_IDLE;
                    acc_d   = '0;
                end else begin
                    state_d = S_WRITE;
                    acc_d   = acc_sum;
                    we_d    = 1'b1;
                    waddr_d = memstartzap + SIZE_address_pix'(o_q);
                    dp_d    = saturate(acc_sum);
                end
            end
            S_WRITE: begin
                acc_d = '0;
                if (!enable) begin
                    state_d = S_IDLE;
                end else if (o_q == O_LAST) begin
                    state_d = S_DONE;
                    stop_d  = 1'b1;
                end else begin
                    state_d  = S_READ;
                    o_d      = o_q + OW'(1);
                    i_d      = '0;
                    rd_d     = 1'b1;
                    raddrp_d = memstartp;
                    raddrw_d = raddrw_q + SIZE_address_wei'(1);
                end
            end
            S_DONE: begin
                if (enable) stop_d = 1'b1;
                else        state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign STOP           = stop_q;
    assign re             = rd_q;
    assign re_wb          = rd_q;
    assign read_addressp  = raddrp_q;
    assign read_addressw  = raddrw_q;
    assign we             = we_q;
    assign write_addressp = waddr_q;
    assign dp             = dp_q;

endmodule

// File: tb/tb_dense_out.sv
// Bench for dense_out: memory models, scoreboard of expected score writes, and a
// dot-product reference computed directly from the memory contents.
module tb_dense_out;
    localparam int SZ  = 12;
    localparam int AP  = 13;
    localparam int AWW = 13;
    localparam int IN  = 16;
    localparam int OUT = 11;
    localparam int SH  = 8;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           enable = 1'b0;
    logic           STOP;
    logic [AP-1:0]  memstartp = '0;
    logic [AP-1:0]  memstartzap = '0;
    logic [SZ-1:0]  qp = '0;
    logic [SZ-1:0]  qw = '0;
    logic           re, re_wb, we;
    logic [AP-1:0]  read_addressp, write_addressp;
    logic [AWW-1:0] read_addressw;
    logic [SZ-1:0]  dp;

    logic [SZ-1:0] pix_mem [0:(1<<AP)-1];
    logic [SZ-1:0] wei_mem [0:(1<<AWW)-1];

    logic [SZ-1:0] exp_q[$];
    logic [AP-1:0] exp_addr_q[$];

    int checks = 0;
    int errors = 0;
    int rd_cnt = 0;
    int rd_base = 0;

    dense_out #(
        .SIZE_1(SZ), .SIZE_address_pix(AP), .SIZE_address_wei(AWW),
        .IN_NUM(IN), .OUT_NUM(OUT), .SHIFT(SH)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .STOP(STOP),
        .memstartp(memstartp), .memstartzap(memstartzap),
        .qp(qp), .re(re), .read_addressp(read_addressp),
        .qw(qw), .re_wb(re_wb), .read_addressw(read_addressw),
        .we(we), .write_addressp(write_addressp), .dp(dp)
    );

    // clock / reset
    always #5 clk = ~clk;

    // synchronous memories, one cycle read latency
    always @(posedge clk) begin
        if (re)    qp <= pix_mem[read_addressp];
        if (re_wb) qw <= wei_mem[read_addressw];
    end

    task automatic check(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // monitor / scoreboard
    always @(negedge clk) begin
        if (re) begin
            check("rd_addr_p", read_addressp, longint'(memstartp) + longint'((rd_cnt - rd_base) % IN));
            check("rd_addr_w", read_addressw, rd_cnt - rd_base);
            check("re_wb_on", re_wb, 1);
            rd_cnt++;
        end else begin
            check("re_wb_off", re_wb, 0);
        end
        if (we) begin
            if (exp_q.size() == 0) begin
                check("unexpected_we", we, 0);
            end else begin
                check("wr_addr", write_addressp, exp_addr_q.pop_front());
                check("wr_data", longint'($signed(dp)), longint'($signed(exp_q.pop_front())));
            end
        end
    end

    // reference: exact dot product, floor division by 2^SH, clamp
    function automatic longint ref_score(input int o);
        longint s, q, d;
        s = 0;
        for (int i = 0; i < IN; i++)
            s += longint'($signed(pix_mem[int'(memstartp) + i])) * longint'($signed(wei_mem[o * IN + i]));
        d = longint'(1) << SH;
        q = s / d;
        if (s < 0 && (s % d) != 0) q = q - 1;
        if (q > 2047) q = 2047;
        if (q < -2048) q = -2048;
        return q;
    endfunction

    // driver tasks
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    function automatic logic [SZ-1:0] gen(input int pat, input bit is_w);
        logic [SZ-1:0] v;
        case (pat)
            1:       v = SZ'(int'($urandom_range(0, 15)) - 8);
            2:       v = 12'd2047;
            3:       v = is_w ? 12'h800 : 12'd2047;
            default: v = SZ'($urandom_range(0, 4095));
        endcase
        return v;
    endfunction

    task automatic fill(input int pat, input int ps, input int pz);
        memstartp   = AP'(ps);
        memstartzap = AP'(pz);
        for (int i = 0; i < IN; i++) pix_mem[ps + i] = gen(pat, 1'b0);
        for (int k = 0; k < OUT * IN; k++) wei_mem[k] = gen(pat, 1'b1);
        if (pat == 4) begin
            // small negative sums distinguish floor from truncation
            for (int i = 0; i < IN; i++) pix_mem[ps + i] = '0;
            pix_mem[ps]     = 12'd7;
            pix_mem[ps + 1] = 12'd1;
            for (int o = 0; o < OUT; o++) begin
                wei_mem[o * IN]     = SZ'(-(o + 1));
                wei_mem[o * IN + 1] = SZ'(o * 64);
            end
        end
    endtask

    task automatic start_job();
        rd_base = rd_cnt;
        exp_q.delete();
        exp_addr_q.delete();
        for (int o = 0; o < OUT; o++) begin
            exp_q.push_back(SZ'(ref_score(o)));
            exp_addr_q.push_back(memstartzap + AP'(o));
        end
        enable = 1'b1;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!STOP && n < 2000);
        check("stop_latency", n - 1, OUT * (IN + 2));
        check("read_count", rd_cnt - rd_base, OUT * IN);
        check("writes_left", exp_q.size(), 0);
    endtask

    task automatic hold_release();
        repeat (20) begin
            step();
            check("stop_hold", STOP, 1);
        end
        enable = 1'b0;
        step();
        check("stop_release", STOP, 0);
        check("re_after_release", re, 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_stop"}, STOP, 0);
        check({tag, "_re"}, re, 0);
        check({tag, "_re_wb"}, re_wb, 0);
        check({tag, "_we"}, we, 0);
        check({tag, "_raddr_p"}, read_addressp, 0);
        check({tag, "_raddr_w"}, read_addressw, 0);
        check({tag, "_waddr"}, write_addressp, 0);
        check({tag, "_dp"}, dp, 0);
    endtask

    initial begin
        int n;
        for (int k = 0; k < (1 << AP); k++) pix_mem[k] = '0;
        for (int k = 0; k < (1 << AWW); k++) wei_mem[k] = '0;

        rst = 1'b1;
        step();
        step();
        check_all_zero("reset");
        rst = 1'b0;
        step();

        // directed address sweep, then an identical rerun
        fill(1, 100, 300);
        start_job();
        wait_done();
        hold_release();
        start_job();
        wait_done();
        hold_release();

        // full-range random, saturation both ways, floor rounding
        for (int p = 0; p <= 4; p++) begin
            if (p == 1) continue;
            fill(p, $urandom_range(0, 3000), $urandom_range(4000, 8000));
            start_job();
            wait_done();
            hold_release();
        end

        // abort during the second output's reads
        fill(0, $urandom_range(0, 3000), $urandom_range(4000, 8000));
        start_job();
        n = 0;
        while ((rd_cnt - rd_base) < IN + 3 && n < 1000) begin
            step();
            n++;
        end
        check("abort_reached", rd_cnt - rd_base, IN + 3);
        enable = 1'b0;
        step();
        check("abort_re", re, 0);
        check("abort_re_wb", re_wb, 0);
        check("abort_we", we, 0);
        check("abort_writes", exp_q.size(), OUT - 1);
        exp_q.delete();
        exp_addr_q.delete();
        repeat (5) step();

        // reset just before the second output's write, then restart with enable held
        fill(1, $urandom_range(0, 3000), $urandom_range(4000, 8000));
        start_job();
        n = 0;
        while (!((rd_cnt - rd_base) >= 2 * IN && !re) && n < 1000) begin
            step();
            n++;
        end
        check("drain_reached", rd_cnt - rd_base, 2 * IN);
        rst = 1'b1;
        step();
        check_all_zero("midrun_reset");
        check("reset_writes", exp_q.size(), OUT - 1);
        rst = 1'b0;
        start_job();
        wait_done();
        hold_release();

        repeat (3) begin
            fill(0, $urandom_range(0, 3000), $urandom_range(4000, 8000));
            start_job();
            wait_done();
            hold_release();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
